// File: rtl/mul_seq_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding
// and the iteration-counter width helper.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier (signed/unsigned); WIDTH cycles per product, or fewer with EARLY_EXIT.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_e          state_q;
  logic [PW-1:0]   acc_q, mcand_q, result_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, in_ready_q, out_valid_q, busy_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_d, mcand_d, prod_d;
  logic [WIDTH-1:0] mplier_d;
  logic [CW-1:0]    cnt_d;
  logic             run_last;

  // Magnitudes are unsigned, so the most-negative operand maps to 2^(WIDTH-1).
  always_comb begin
    a_neg    = signed_mode & a_in[WIDTH-1];
    b_neg    = signed_mode & b_in[WIDTH-1];
    a_mag    = a_neg ? ('0 - a_in) : a_in;
    b_mag    = b_neg ? ('0 - b_in) : b_in;
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    cnt_d    = cnt_q - CW'(1);
    run_last = (cnt_d == '0) || (EARLY_EXIT && (mplier_d == '0));
    prod_d   = neg_q ? ('0 - acc_d) : acc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_q    <= PW'(a_mag);
            mplier_q   <= b_mag;
            acc_q      <= '0;
            cnt_q      <= CW'(WIDTH);
            neg_q      <= a_neg ^ b_neg;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          if (run_last) begin
            result_q    <= prod_d;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          // Return to IDLE only; new operands wait for the next cycle.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and random checks of mul_seq at WIDTH=8 (both EARLY_EXIT settings) and WIDTH=16.
module tb_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready, signed_mode;
  logic [7:0]  a_in, b_in;
  logic        rdy0, ov0, busy0, rdy1, ov1, busy1;
  logic [15:0] res0, res1;

  logic        iv16, or16, sm16;
  logic [15:0] a16, b16;
  logic        rdy2, ov2, busy2;
  logic [31:0] res2;

  mul_seq #(.WIDTH(8), .EARLY_EXIT(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .a_in(a_in), .b_in(b_in), .signed_mode(signed_mode),
    .out_valid(ov0), .out_ready(out_ready), .result(res0), .busy(busy0));

  mul_seq #(.WIDTH(8), .EARLY_EXIT(1'b1)) u8e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a_in(a_in), .b_in(b_in), .signed_mode(signed_mode),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .busy(busy1));

  mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy2),
    .a_in(a16), .b_in(b16), .signed_mode(sm16),
    .out_valid(ov2), .out_ready(or16), .result(res2), .busy(busy2));

  typedef struct {
    logic [15:0] p;
    int          lat_e;
  } exp8_t;

  exp8_t       q8[$];
  logic [31:0] q16[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint ai, bi, p;
    ai = s ? longint'($signed(a)) : longint'(a);
    bi = s ? longint'($signed(b)) : longint'(b);
    p  = ai * bi;
    return p[15:0];
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint ai, bi, p;
    ai = s ? longint'($signed(a)) : longint'(a);
    bi = s ? longint'($signed(b)) : longint'(b);
    p  = ai * bi;
    return p[31:0];
  endfunction

  // Early-exit latency: 1 + index of the top set bit of |b|, or 1 when b is zero.
  function automatic int ee_lat(input logic [7:0] b, input logic s);
    logic [7:0] m;
    int         h;
    m = b;
    if (s && b[7]) m = ~b + 8'd1;
    h = 0;
    for (int i = 0; i < 8; i++) if (m[i]) h = i + 1;
    return (h == 0) ? 1 : h;
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input int hold);
    exp8_t e;
    int    n, l0, l1;
    e.p     = ref8(a, b, s);
    e.lat_e = ee_lat(b, s);
    q8.push_back(e);
    a_in = a; b_in = b; signed_mode = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in = ~a; b_in = ~b; signed_mode = ~s;
    l0 = 0; l1 = 0; n = 0;
    while ((l0 == 0 || l1 == 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ov0 && l0 == 0) l0 = n;
      if (ov1 && l1 == 0) l1 = n;
    end
    e = q8.pop_front();
    chk("lat", 32'(l0), 32'd8);
    chk("lat_ee", 32'(l1), 32'(e.lat_e));
    chk("res", 32'(res0), 32'(e.p));
    chk("res_ee", 32'(res1), 32'(e.p));
    chk("busy_done", 32'(busy0), 32'd1);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_ov", 32'(ov0), 32'd1);
      chk("hold_res", 32'(res0), 32'(e.p));
      chk("hold_rdy", 32'(rdy0), 32'd0);
    end
    // in_valid asserted on the handshake edge must not start a new operation.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("ack_ov", 32'(ov0), 32'd0);
    chk("ack_ov_ee", 32'(ov1), 32'd0);
    chk("ack_rdy", 32'(rdy0), 32'd1);
    chk("ack_busy", 32'(busy0), 32'd0);
    chk("ack_busy_ee", 32'(busy1), 32'd0);
    chk("keep_res", 32'(res0), 32'(e.p));
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [31:0] e;
    int          n, l, d;
    q16.push_back(ref16(a, b, s));
    a16 = a; b16 = b; sm16 = s; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    l = 0; n = 0;
    while (l == 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ov2) l = n;
    end
    e = q16.pop_front();
    chk("lat16", 32'(l), 32'd16);
    chk("res16", res2, e);
    d = $urandom_range(0, 2);
    for (int k = 0; k < d; k++) begin
      @(posedge clk); #1;
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("rdy16", 32'(rdy2), 32'd1);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; signed_mode = 1'b0;
    a_in = '0; b_in = '0; iv16 = 1'b0; or16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy0), 32'd1);
    chk("rst_ov", 32'(ov0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_res", 32'(res0), 32'd0);
    chk("rst_res_ee", 32'(res1), 32'd0);
    chk("rst_busy16", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8(8'd200, 8'd150, 1'b0, 0);
    op8(8'h80, 8'h80, 1'b1, 0);
    op8(8'hF9, 8'd5, 1'b1, 0);
    op8(8'd55, 8'd0, 1'b0, 0);
    op8(8'd3, 8'h80, 1'b0, 0);
    op8(8'd17, 8'hFF, 1'b1, 5);
    op8(8'hFF, 8'hFF, 1'b0, 0);

    // Abort in the third RUN cycle.
    a_in = 8'd9; b_in = 8'd9; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_rdy", 32'(rdy0), 32'd1);
    chk("abort_res", 32'(res0), 32'd0);
    chk("abort_ov", 32'(ov0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_res_ee", 32'(res1), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ov0 || ov1) seen = 1'b1;
    end
    chk("abort_no_ov", 32'(seen), 32'd0);
    op8(8'd3, 8'd4, 1'b0, 0);

    for (int i = 0; i < 20; i++)
      op8(8'($urandom), 8'($urandom) >> $urandom_range(0, 7), 1'($urandom_range(0, 1)), 0);

    op16(16'hFFFF, 16'hFFFF, 1'b0);
    op16(16'h8000, 16'h8000, 1'b1);
    op16(16'h8000, 16'h7FFF, 1'b1);
    for (int i = 0; i < 300; i++) op16(16'($urandom), 16'($urandom), 1'b0);
    for (int i = 0; i < 300; i++) op16(16'($urandom), 16'($urandom), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
